fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator between `insMem` and the decode/register-file stage of `cpu`. It drives instruction-memory read addresses and splits each returned 64-bit word into two 32-bit instructions. These are queued in a small buffer and handed to decode over a valid/ready handshake. A PC redirect from execute flushes the buffer and any in-flight read.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address / PC width.
- `RESET_PC`, 0, first fetch address after reset; must be 8-byte aligned.
- `DEPTH`, 4, instruction-buffer entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `mem_rd_en`  out  1  read request to `insMem`.
- `mem_addr`  out  ADDR_W  byte address of the requested word; bits [2:0] always 0.
- `mem_rdata`  in  64  read data, valid exactly one cycle after the request.
  - [31:0] is the instruction at `addr`.
  - [63:32] is the instruction at `addr+4`.
- `redirect_valid`  in  1  one-cycle pulse requesting a PC change.
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] ignored.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a valid instruction.
- `out_ready`  in  1  decode accepts this cycle.
- `out_instr`  out  32  instruction.
- `out_pc`  out  ADDR_W  byte address of `out_instr`.

## Operation
- Core state:
  - `fetch_pc`: next word address, 8-aligned.
  - `skip_low`: drop the low half of the next word returned.
  - `inflight`: a read is outstanding (0/1).
  - `squash`: discard the outstanding read's data.
  - Circular buffer of {pc, instr}, with `count` 0..DEPTH.
- FSM:
  - BOOT: first cycle after reset release. No request is issued. Always → RUN.
  - RUN: normal fetching.
  - There is no other state.
- Issue rule in RUN: assert `mem_rd_en` when `count + 2*inflight + 2 <= DEPTH` and `redirect_valid` is 0. On issue, `fetch_pc <= fetch_pc + 8`, wrapping modulo 2^ADDR_W.
- Response, in the cycle after an issue, when `squash` is 0:
  - Enqueue the low half at pc = A, unless `skip_low` is set; `skip_low` then clears.
  - Enqueue the high half at pc = A+4.
  - The issue rule guarantees space, so there is no overflow path.
- Output:
  - `out_valid` = (`count` != 0).
  - `out_instr`/`out_pc` are the buffer head, driven from registers with no combinational path from `out_ready`.
  - Head pops when `out_valid && out_ready`.
  - Enqueue and pop in the same cycle are both honored.
- Redirect (`redirect_valid` = 1 at an edge):
  - A handshake in that same cycle still completes.
  - Then the buffer is emptied (`count <= 0`).
  - `fetch_pc <= {redirect_pc[ADDR_W-1:3], 3'b0}`.
  - `skip_low <= redirect_pc[2]`.
  - No issue occurs that cycle.
  - An outstanding read sets `squash`; its data arriving next cycle is discarded and `squash` clears.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state returns to reset values at once. A read outstanding at reset is ignored.

## Timing
- Reset values:
  - `mem_rd_en` = 0, `mem_addr` = RESET_PC.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - `count` = 0, `inflight` = 0, `squash` = 0, `skip_low` = 0.
- First request occurs in the second cycle after reset deasserts, following the BOOT cycle.
- Memory-to-output latency: request at edge N → data enqueued at edge N+1 → `out_valid` high during cycle N+1.
- Redirect to first valid output: 2 cycles. Redirect at edge R, request issued at edge R+1, `out_valid` high after edge R+2.
- Sustained throughput with `out_ready` held high: one instruction per cycle.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W` = 32, `MEMW_W` = 64.
  - FSM state enum {BOOT, RUN}.
  - Typedef `fetch_entry_t` {pc, instr}.
- Natural sub-module: `fetch_buffer`, a DEPTH-entry circular FIFO.
  - Inputs: 2-wide enqueue with per-lane valid, 1-wide dequeue, flush.
  - Outputs: exports `count`.
- `fetch_unit` contains the FSM, PC/issue logic and redirect/squash control.

## Test plan
- Reset release with RESET_PC = 0 and `out_ready` = 1:
  - Requests at addresses 0x0, 0x8, 0x10…
  - Outputs pcs 0x0, 0x4, 0x8… one per cycle; `out_instr` matches memory halves.
- `out_ready` held 0:
  - `count` reaches 4 and requests stop.
  - No entry is lost or duplicated after `out_ready` returns to 1.
- Redirect to 0x104 while a read is in flight:
  - Squashed data never appears on the output.
  - Next outputs are pcs 0x104, 0x108, 0x10C; the 0x100 half is skipped.
- Redirect in the same cycle as an accepted handshake:
  - The accepted instruction counts as delivered.
  - Buffer flushes; next `out_pc` = redirect target.
- Wrap-around: redirect to 0xFFFF_FFF8. Outputs pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- `reset` asserted asynchronously mid-stream with the buffer at 3 entries:
  - `out_valid` drops immediately without waiting for a clock edge.
  - After release, fetch restarts from RESET_PC following the BOOT cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and widths shared by the instruction-fetch slice of the cpu.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned MEMW_W  = 64;
  // PC field is sized for the widest supported ADDR_W; narrower PCs are zero-extended.
  localparam int unsigned PC_W    = 64;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry circular instruction buffer: two enqueue lanes, one dequeue, flush.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [1:0]               enq_valid_i,
  input  fetch_entry_t [1:0]       enq_entry_i,
  input  logic                     deq_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr1_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             deq;

  always_comb begin
    deq = deq_i && (count_q != '0);
    // Lane 1 packs down into lane 0's slot when the low half is skipped.
    wr1_ptr  = enq_valid_i[0] ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_valid_i[0]) + PTR_W'(enq_valid_i[1]);
    count_d  = count_q + CNT_W'(enq_valid_i[0]) + CNT_W'(enq_valid_i[1]) - CNT_W'(deq);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (!flush_i) begin
        if (enq_valid_i[0]) mem_q[wr_ptr_q] <= enq_entry_i[0];
        if (enq_valid_i[1]) mem_q[wr1_ptr]  <= enq_entry_i[1];
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues 64-bit reads, splits them into two
// instructions, buffers them and hands them to decode; redirects flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [MEMW_W-1:0]   mem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 2;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              skip_low_q, skip_low_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;

  logic [CNT_W-1:0]   count;
  logic [OCC_W-1:0]   occ;
  logic               issue;
  logic               resp;
  logic [1:0]         enq_valid;
  fetch_entry_t [1:0] enq_entry;
  fetch_entry_t       head;
  logic               unused_bits;

  always_comb begin
    // Space reserved for buffered entries, the outstanding read and this one.
    occ   = OCC_W'(count) + (inflight_q ? OCC_W'(2) : '0) + OCC_W'(2);
    issue = (state_q == RUN) && !redirect_valid && (occ <= OCC_W'(DEPTH));
    resp  = inflight_q && !squash_q;

    enq_valid          = {resp, resp && !skip_low_q};
    enq_entry[0].pc    = PC_W'(rd_addr_q);
    enq_entry[0].instr = mem_rdata[INSTR_W-1:0];
    enq_entry[1].pc    = PC_W'(rd_addr_q + ADDR_W'(4));
    enq_entry[1].instr = mem_rdata[MEMW_W-1:INSTR_W];
  end

  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    rd_addr_d  = rd_addr_q;
    skip_low_d = skip_low_q;
    inflight_d = issue;
    squash_d   = 1'b0;
    if (resp) skip_low_d = 1'b0;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(8);
      rd_addr_d  = fetch_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:3], 3'b000};
      skip_low_d = redirect_pc[2];
      squash_d   = inflight_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rd_addr_q  <= RESET_PC;
      skip_low_q <= 1'b0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_addr_q  <= rd_addr_d;
      skip_low_q <= skip_low_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (redirect_valid),
    .enq_valid_i (enq_valid),
    .enq_entry_i (enq_entry),
    .deq_i       (out_valid && out_ready),
    .head_o      (head),
    .count_o     (count)
  );

  assign mem_rd_en   = issue;
  assign mem_addr    = fetch_pc_q;
  assign out_valid   = (count != '0);
  assign out_instr   = head.instr;
  assign out_pc      = ADDR_W'(head.pc);
  assign unused_bits = ^{redirect_pc[1:0], head.pc};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {pc, instr}
// sequences; a negedge monitor pops and compares on every handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  logic        req_pend = 1'b0;
  logic [31:0] req_addr = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = imem(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the redirect edge.
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Instruction memory: request seen before edge N, data valid after edge N.
  always @(negedge clk) begin
    req_pend = mem_rd_en;
    req_addr = mem_addr;
    if (reset && mem_rd_en) check("mem_addr_align", 64'(mem_addr[2:0]), 64'd0);
  end

  always @(posedge clk) begin
    if (req_pend) mem_rdata <= {imem(req_addr + 32'd4), imem(req_addr)};
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_pc", 64'(out_pc), 64'(e.pc));
      check("out_instr", 64'(out_instr), 64'(e.instr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned reqs;
    int unsigned k;
    logic        found;

    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);

    // Release: BOOT cycle issues nothing, first request follows.
    @(negedge clk); reset = 1'b1; #1;
    check("boot_no_req", 64'(mem_rd_en), 64'd0);
    @(posedge clk); #1;
    check("first_req_en",   64'(mem_rd_en), 64'd1);
    check("first_req_addr", 64'(mem_addr),  64'd0);
    push_seq(32'h0, 16);
    out_ready = 1'b1;
    drain("drain_stream");

    // Redirect to 0x104 while a read is outstanding.
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      @(negedge clk);
      found = mem_rd_en;
      k++;
    end
    check("squash_req_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    redirect(32'h104);
    exp_q.delete();
    push_seq(32'h104, 4);
    drain("drain_squash");

    // Backpressure: buffer fills to DEPTH and requests stop.
    out_ready = 1'b0;
    redirect(32'h200);
    exp_q.delete();
    reqs = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_rd_en) reqs++;
    end
    check("bp_req_count", 64'(reqs), 64'd2);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    push_seq(32'h200, 10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_bp");

    // Redirect coinciding with an accepted handshake.
    redirect(32'h400);
    exp_q.delete();
    push_seq(32'h400, 6);
    k = 0;
    while (exp_q.size() > 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("hs_valid_at_redirect", 64'(out_valid), 64'd1);
    redirect(32'h508);
    check("hs_delivered", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    push_seq(32'h508, 4);
    drain("drain_hs_redirect");

    // Address wrap-around.
    redirect(32'hFFFF_FFF8);
    exp_q.delete();
    push_seq(32'hFFFF_FFF8, 5);
    drain("drain_wrap");

    // Asynchronous reset with three entries buffered.
    out_ready = 1'b0;
    redirect(32'h304);
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_pc",    64'(out_pc),    64'd0);
    check("async_rst_instr", 64'(out_instr), 64'd0);
    check("async_rst_rd_en", 64'(mem_rd_en), 64'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    check("reboot_no_req", 64'(mem_rd_en), 64'd0);
    @(posedge clk); #1;
    check("reboot_req_en",   64'(mem_rd_en), 64'd1);
    check("reboot_req_addr", 64'(mem_addr),  64'd0);
    push_seq(32'h0, 8);
    out_ready = 1'b1;
    drain("drain_reboot");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
